// File: rtl/fp_sched_pkg.sv
// Shared types and helpers for the floating-point add/subtract scheduler.
//   state_t    : scheduler FSM states
//   OP_W_DEF   : default operand width (IEEE-754 single)
//   clog2_safe : ceil(log2(value)), never below 1, for index/counter widths
package fp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int OP_W_DEF = 32;

  // Width needed to hold 0..value-1; a single-entry range still gets 1 bit.
  function automatic int clog2_safe(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req [N-1:0]     : request vector
//   ptr [IDX_W-1:0] : highest-priority index this cycle (must be < N)
//   gnt [N-1:0]     : one-hot grant, zero when no request is set
// Priority starts at ptr and wraps from N-1 back to 0.
module rr_arbiter import fp_sched_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_safe(N)-1:0]   ptr,
  output logic [N-1:0]               gnt
);

  localparam int IDX_W = clog2_safe(N);
  localparam int SUMW  = IDX_W + 1;
  localparam logic [SUMW-1:0] N_V = SUMW'(N);

  logic [SUMW-1:0]  sum_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Scan from ptr upward with wrap; first requester found wins.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract implements mod N.
      sum_s = {1'b0, ptr} + SUMW'(k);
      if (sum_s >= N_V) begin
        sum_s = sum_s - N_V;
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDX_W-1:0];
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one floating-point add/subtract unit among
// N requesters, with a watchdog so a hung unit cannot stall the clients.
//   clk, n_rst        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester request handshake (ready is one-hot)
//   req_mode/op1/op2  : per-requester op (0 add, 1 sub) and packed operands
//   add_start         : one-cycle start pulse to the unit
//   mode/op1/op2      : registered operation to the unit
//   add_result/done/overflow : unit response
//   resp_valid/ready  : one-hot response handshake to the owning requester
//   resp_result/overflow/timeout : captured response data
//   busy              : high whenever the scheduler is not idle
module fp_addsub_sched import fp_sched_pkg::*; #(
  parameter int N       = 4,
  parameter int OP_W    = OP_W_DEF,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N-1:0]       req_mode,
  input  logic [N*OP_W-1:0]  req_op1,
  input  logic [N*OP_W-1:0]  req_op2,
  output logic               add_start,
  output logic               mode,
  output logic [OP_W-1:0]    op1,
  output logic [OP_W-1:0]    op2,
  input  logic [RES_W-1:0]   add_result,
  input  logic               add_done,
  input  logic               add_overflow,
  output logic [N-1:0]       resp_valid,
  input  logic [N-1:0]       resp_ready,
  output logic [RES_W-1:0]   resp_result,
  output logic               resp_overflow,
  output logic               resp_timeout,
  output logic               busy
);

  localparam int IDX_W = clog2_safe(N);
  localparam int CNT_W = clog2_safe(TIMEOUT);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              add_start_q, add_start_d;
  logic              mode_q, mode_d;
  logic [OP_W-1:0]   op1_q, op1_d;
  logic [OP_W-1:0]   op2_q, op2_d;
  logic [N-1:0]      resp_valid_q, resp_valid_d;
  logic [RES_W-1:0]  resp_result_q, resp_result_d;
  logic              resp_overflow_q, resp_overflow_d;
  logic              resp_timeout_q, resp_timeout_d;
  logic              busy_q, busy_d;

  logic [N-1:0]      gnt_s;
  logic [N-1:0]      req_ready_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              hs_s;

  rr_arbiter #(.N(N)) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (gnt_s)
  );

  // Grant is only offered while idle; encode the one-hot grant to an index.
  always_comb begin
    req_ready_s = (state_q == IDLE) ? gnt_s : '0;
    hs_s        = |(req_valid & req_ready_s);
    gnt_idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      gnt_idx_s = gnt_idx_s | (gnt_s[i] ? IDX_W'(i) : '0);
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    gidx_d          = gidx_q;
    cnt_d           = cnt_q;
    add_start_d     = 1'b0;
    mode_d          = mode_q;
    op1_d           = op1_q;
    op2_d           = op2_q;
    resp_valid_d    = resp_valid_q;
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    resp_timeout_d  = resp_timeout_q;
    busy_d          = busy_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          gidx_d      = gnt_idx_s;
          mode_d      = req_mode[gnt_idx_s];
          op1_d       = req_op1[int'(gnt_idx_s)*OP_W +: OP_W];
          op2_d       = req_op2[int'(gnt_idx_s)*OP_W +: OP_W];
          rr_d        = (gnt_idx_s == IDX_W'(N-1)) ? '0 : gnt_idx_s + IDX_W'(1);
          add_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done in the final watchdog cycle still wins over the timeout.
        if (add_done) begin
          resp_result_d   = add_result;
          resp_overflow_d = add_overflow;
          resp_timeout_d  = 1'b0;
          resp_valid_d    = {{(N-1){1'b0}}, 1'b1} << gidx_q;
          state_d         = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          resp_result_d   = '0;
          resp_overflow_d = 1'b0;
          resp_timeout_d  = 1'b1;
          resp_valid_d    = {{(N-1){1'b0}}, 1'b1} << gidx_q;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Only the owner's ready bit closes the response.
        if (resp_ready[gidx_q]) begin
          resp_valid_d = '0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_valid_d = '0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      rr_q            <= '0;
      gidx_q          <= '0;
      cnt_q           <= '0;
      add_start_q     <= 1'b0;
      mode_q          <= 1'b0;
      op1_q           <= '0;
      op2_q           <= '0;
      resp_valid_q    <= '0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_timeout_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_q            <= rr_d;
      gidx_q          <= gidx_d;
      cnt_q           <= cnt_d;
      add_start_q     <= add_start_d;
      mode_q          <= mode_d;
      op1_q           <= op1_d;
      op2_q           <= op2_d;
      resp_valid_q    <= resp_valid_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_timeout_q  <= resp_timeout_d;
      busy_q          <= busy_d;
    end
  end

  assign req_ready     = req_ready_s;
  assign add_start     = add_start_q;
  assign mode          = mode_q;
  assign op1           = op1_q;
  assign op2           = op2_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_timeout  = resp_timeout_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Scoreboard bench for fp_addsub_sched: a stub unit checks issued operations
// against an issue queue, a monitor checks every accepted response against a
// response queue, and directed stimulus covers add, subtract, round robin,
// timeout, backpressure with overflow and reset mid-operation.
module tb_fp_addsub_sched;
  localparam int N       = 4;
  localparam int OP_W    = 32;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 64;

  logic              clk;
  logic              n_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_mode;
  logic [N*OP_W-1:0] req_op1;
  logic [N*OP_W-1:0] req_op2;
  logic              add_start;
  logic              mode;
  logic [OP_W-1:0]   op1;
  logic [OP_W-1:0]   op2;
  logic [RES_W-1:0]  add_result;
  logic              add_done;
  logic              add_overflow;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [RES_W-1:0]  resp_result;
  logic              resp_overflow;
  logic              resp_timeout;
  logic              busy;

  fp_addsub_sched #(.N(N), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_op1(req_op1), .req_op2(req_op2),
    .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
    .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_timeout(resp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        m;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] res;
    logic        ovf;
    logic        to;
  } rsp_t;

  iss_t iq[$];
  rsp_t rq[$];

  int          checks   = 0;
  int          failures = 0;
  int          stub_lat = 0;
  logic [31:0] stub_res = 32'h0;
  logic        stub_ovf = 1'b0;
  int          late_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_req_ready"}, 64'(req_ready), 64'd0);
    check({name, "_add_start"}, 64'(add_start), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({name, "_flags"}, 64'({mode, resp_overflow, resp_timeout}), 64'd0);
    check({name, "_op1_op2"}, {op1, op2}, 64'd0);
    check({name, "_resp_result"}, 64'(resp_result), 64'd0);
  endtask

  // Stub arithmetic unit: done stub_lat cycles after start (0 = never).
  initial begin
    int   cd;
    int   late_ack;
    logic prev_start;
    iss_t e;
    cd = 0; late_ack = 0; prev_start = 1'b0;
    add_done = 1'b0; add_result = 32'hDEADBEEF; add_overflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      add_done = 1'b0; add_result = 32'hDEADBEEF; add_overflow = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          add_done = 1'b1; add_result = stub_res; add_overflow = stub_ovf;
        end
      end
      if (late_req != late_ack) begin
        late_ack = late_req;
        add_done = 1'b1;
      end
      if (add_start === 1'b1) begin
        check("start_single_cycle", 64'(prev_start), 64'd0);
        check("start_expected", 64'(iq.size() > 0), 64'd1);
        if (iq.size() > 0) begin
          e = iq.pop_front();
          check("issue_mode", 64'(mode), 64'(e.m));
          check("issue_op1", 64'(op1), 64'(e.a));
          check("issue_op2", 64'(op2), 64'(e.b));
        end
        if (stub_lat > 0) cd = stub_lat;
      end
      prev_start = add_start;
    end
  end

  // Monitor: compare each response on the cycle it is accepted.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if ((resp_valid & resp_ready) != '0) begin
        check("resp_expected", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) begin
          e = rq.pop_front();
          check("resp_owner", 64'(resp_valid), 64'(4'b0001 << e.idx));
          check("resp_result", 64'(resp_result), 64'(e.res));
          check("resp_overflow", 64'(resp_overflow), 64'(e.ovf));
          check("resp_timeout", 64'(resp_timeout), 64'(e.to));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic wait_idle(input string name);
    for (int c = 0; c < 300 && busy !== 1'b0; c++) @(negedge clk);
    @(negedge clk);
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input int r, input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf, input logic to, output int lat);
    logic got;
    logic seen;
    iq.push_back('{m: m, a: a, b: b});
    rq.push_back('{idx: 2'(r), res: res, ovf: ovf, to: to});
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_mode[r] = m;
    req_op1[r*OP_W +: OP_W] = a;
    req_op2[r*OP_W +: OP_W] = b;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check("grant", 64'(req_ready), 64'(4'b0001 << r));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    check("start_at_t1", 64'(add_start), 64'd1);
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (resp_valid != '0) seen = 1'b1;
    end
    check("resp_seen", 64'(seen), 64'd1);
    check("mode_held", 64'(mode), 64'(m));
    check("op1_held", 64'(op1), 64'(a));
  endtask

  initial begin
    int         lat;
    int         ng;
    logic [3:0] order [5];
    n_rst = 1'b0;
    req_valid = '0; req_mode = '0; req_op1 = '0; req_op2 = '0;
    resp_ready = 4'b1111;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Single add from requester 1: 1.25 + 1.50 = 2.75.
    stub_lat = 3; stub_res = 32'h40300000; stub_ovf = 1'b0;
    run_op(1, 1'b0, 32'h3FA00000, 32'h3FC00000, 32'h40300000, 1'b0, 1'b0, lat);
    check("add_latency", 64'(lat), 64'd4);
    wait_idle("idle_after_add");

    // Subtract from requester 3: 1.50 - 1.25 = 0.25.
    stub_res = 32'h3E800000;
    run_op(3, 1'b1, 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 1'b0, lat);
    check("sub_result_at_resp", 64'(resp_result), 64'h3E800000);
    wait_idle("idle_after_sub");

    // Round robin, pointer now 0: expect 0,1,2,3,0.
    stub_lat = 1; stub_res = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      iq.push_back('{m: 1'b0, a: 32'h10000000 + 32'(i % 4), b: 32'h20000000 + 32'(i % 4)});
      rq.push_back('{idx: 2'(i % 4), res: 32'h12345678, ovf: 1'b0, to: 1'b0});
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_mode[i] = 1'b0;
      req_op1[i*OP_W +: OP_W] = 32'h10000000 + 32'(i);
      req_op2[i*OP_W +: OP_W] = 32'h20000000 + 32'(i);
    end
    req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 200 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        order[ng] = req_ready;
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("rr_grant_count", 64'(ng), 64'd5);
    check("rr_grant_0", 64'(order[0]), 64'h1);
    check("rr_grant_1", 64'(order[1]), 64'h2);
    check("rr_grant_2", 64'(order[2]), 64'h4);
    check("rr_grant_3", 64'(order[3]), 64'h8);
    check("rr_grant_4", 64'(order[4]), 64'h1);
    wait_idle("idle_after_rr");

    // Timeout: unit never answers; pointer is 1, requester 2 wins.
    stub_lat = 0;
    run_op(2, 1'b0, 32'h40000000, 32'h40400000, 32'h0, 1'b0, 1'b1, lat);
    check("timeout_latency", 64'(lat), 64'(TIMEOUT + 1));
    wait_idle("idle_after_timeout");
    late_req++;
    repeat (3) @(negedge clk);
    check("late_done_busy", 64'(busy), 64'd0);
    check("late_done_resp_valid", 64'(resp_valid), 64'd0);
    check("late_done_add_start", 64'(add_start), 64'd0);

    // Backpressure with overflow on requester 2; other ready bits ignored.
    stub_lat = 2; stub_res = 32'h7F800000; stub_ovf = 1'b1;
    resp_ready = 4'b1011;
    run_op(2, 1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, lat);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_resp_valid", 64'(resp_valid), 64'h4);
      check("bp_resp_result", 64'(resp_result), 64'h7F800000);
      check("bp_resp_overflow", 64'(resp_overflow), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    resp_ready = 4'b1111;
    wait_idle("idle_after_bp");

    // Reset mid-WAIT: pointer is 3, requester 1 wins and moves it to 2.
    stub_lat = 0; stub_ovf = 1'b0;
    iq.push_back('{m: 1'b0, a: 32'h3F800000, b: 32'h3F800000});
    @(posedge clk); #1;
    req_mode[1] = 1'b0;
    req_op1[1*OP_W +: OP_W] = 32'h3F800000;
    req_op2[1*OP_W +: OP_W] = 32'h3F800000;
    req_valid[1] = 1'b1;
    ng = 0;
    for (int c = 0; c < 50 && ng == 0; c++) begin
      @(negedge clk);
      if (req_ready != '0) ng = 1;
    end
    check("mid_rst_grant", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(negedge clk);
    check("mid_rst_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Pointer cleared: with 0 and 2 valid, requester 0 wins.
    stub_lat = 2; stub_res = 32'h40490FDB;
    iq.push_back('{m: 1'b0, a: 32'h40000000, b: 32'h3F800000});
    rq.push_back('{idx: 2'd0, res: 32'h40490FDB, ovf: 1'b0, to: 1'b0});
    req_mode[0] = 1'b0;
    req_op1[0*OP_W +: OP_W] = 32'h40000000;
    req_op2[0*OP_W +: OP_W] = 32'h3F800000;
    req_valid = 4'b0101;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("idle_after_post_rst");

    check("iq_empty", 64'(iq.size()), 64'd0);
    check("rq_empty", 64'(rq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_addsub_sched.md
Name: fp_addsub_sched

Overview:
- Round-robin scheduler that shares one floating-point add/subtract unit (addsub) between N requesters.
- Accepts operation requests over a valid/ready handshake and pulses the unit's start input.
- Waits for the unit's done output, then returns the result and flags to the requester that was granted.
- Sits between the FPU front-end clients and the single addsub instance; includes a watchdog so a hung unit cannot stall the clients.

Parameters:
- N, 4, number of requesters (2..8)
- OP_W, 32, operand width (IEEE-754 single)
- RES_W, 32, result width returned by the arithmetic unit
- TIMEOUT, 64, maximum cycles to wait for add_done before aborting (>= 2)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req_valid  in  N  per-requester request valid
- req_ready  out  N  one-hot accept; at most one bit high per cycle
- req_mode  in  N  per-requester op: 0 = add, 1 = subtract
- req_op1  in  N*OP_W  packed operand 1, requester i at [i*OP_W +: OP_W]
- req_op2  in  N*OP_W  packed operand 2, same packing
- add_start  out  1  one-cycle start pulse to the unit
- mode  out  1  registered op mode to the unit
- op1, op2  out  OP_W  registered operands to the unit
- add_result  in  RES_W  unit result
- add_done  in  1  unit completion pulse
- add_overflow  in  1  unit overflow flag, valid with add_done
- resp_valid  out  N  one-hot response valid to the owning requester
- resp_ready  in  N  per-requester response accept
- resp_result  out  RES_W  captured result
- resp_overflow  out  1  captured overflow
- resp_timeout  out  1  1 = unit did not respond within TIMEOUT
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; timeout counter 0.
- States:
  - IDLE: req_ready is the round-robin grant among req_valid; it is combinational, and zero when no request is valid.
  - IDLE exit: on a handshake (req_valid[g] & req_ready[g]), latch g, req_mode[g], req_op1[g] and req_op2[g] into mode/op1/op2, set rr pointer to (g+1) mod N, and go to ISSUE.
  - ISSUE: add_start = 1 for exactly this one cycle, then go to WAIT. Counter is cleared.
  - WAIT: add_start = 0; counter increments each cycle.
  - WAIT exit on done: if add_done, capture add_result and add_overflow, set resp_timeout = 0, go to RESP.
  - WAIT exit on timeout: if the counter reaches TIMEOUT-1 without add_done, set resp_result = 0, resp_overflow = 0, resp_timeout = 1, go to RESP.
  - WAIT tie: add_done takes priority over timeout in the same cycle.
  - RESP: resp_valid[g] = 1 and all response data held stable until resp_ready[g] = 1, then go to IDLE. resp_ready on other bits is ignored.
- Latency: request handshake at cycle T; add_start at T+1; resp_valid at D+1, where D is the cycle add_done is sampled. Back-to-back ops cost 3 cycles plus the unit's latency.
- mode, op1 and op2 are held stable from ISSUE through RESP.
- add_done outside WAIT is ignored, including a stale done after a timeout.
- req_ready is 0 in every state other than IDLE; requesters hold req_valid and their data until accepted.
- Fairness: priority starts at the rr pointer and wraps (N-1 -> 0). A continuously requesting client waits at most N-1 grants.
- Reset mid-operation returns to IDLE immediately, drops any pending response and clears the pointer.

Decomposition:
- Package fp_sched_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}
  - localparam OP_W_DEF = 32
  - function clog2_safe for the index and counter widths
- Sub-module rr_arbiter (N parameter): combinational one-hot grant from request vector and pointer. The pointer register stays in fp_addsub_sched.

Test Plan:
- Single add, N=4: req 1 with op1=0x3FA00000 (1.25), op2=0x3FC00000 (1.50), mode=0; the stub asserts done 3 cycles after start with result 0x40300000 -> add_start one cycle at T+1, resp_valid=4'b0010, resp_result=0x40300000, resp_overflow=0.
- Subtract: op1=0x3FC00000, op2=0x3FA00000, mode=1; stub returns 0x3E800000 -> mode=1 held through RESP, resp_result=0x3E800000.
- Round robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0 with no requester granted twice before the others.
- Timeout: stub never asserts done, TIMEOUT=64 -> resp_timeout=1, resp_result=0; a late done pulse in IDLE leaves state unchanged.
- Backpressure and overflow: requester 2 holds resp_ready=0 for 10 cycles while stub returns overflow=1 -> resp data and resp_overflow=1 stable, req_ready stays 0, busy=1.
- Reset mid-WAIT: n_rst low for 1 cycle -> all outputs 0, state IDLE; the next grant goes to requester 0 if it is valid.
